// File: rtl/player_press_gen.sv
// ---------------------------------------------------------------------------
// player_press_gen
//
// Turns one player's raw board key into a single-cycle press pulse for the
// tug-of-war light cells (one instance per player). With the CPU_PLAYER_EN
// macro defined, an LFSR-driven computer player can drive the pulse instead
// of the human, at a rate set by the speed switches.
//
// Configuration macro: CPU_PLAYER_EN
//   defined   -> LFSR, decision divider and compare are built; cpu_mode
//                selects the press source.
//   undefined -> human key only; cpu_mode, speed, TICK_CYCLES and LFSR_SEED
//                are ignored. The port list is identical in both builds.
//
// Parameters:
//   TICK_CYCLES  CPU decision interval in clocks (>= 2)
//   LFSR_SEED    LFSR value after Reset (must not be 10'h3FF, the XNOR
//                lock-up state)
//
// Ports:
//   Clock     in   single clock
//   Reset     in   synchronous active-high full reset
//   freset    in   synchronous active-high round restart (LFSR keeps running)
//   key_n     in   raw active-low key, asynchronous to Clock
//   cpu_mode  in   1 = computer drives press, human key ignored
//   speed     in   [8:0] CPU aggressiveness, 0 = never presses
//   press     out  registered one-cycle press pulse
// ---------------------------------------------------------------------------
module player_press_gen #(
    parameter int         TICK_CYCLES = 1024,
    parameter logic [9:0] LFSR_SEED   = 10'h000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       freset,
    input  logic       key_n,
    input  logic       cpu_mode,
    input  logic [8:0] speed,
    output logic       press
);

    typedef enum logic [0:0] {
        ST_RELEASED = 1'b0,
        ST_HELD     = 1'b1
    } key_state_e;

    logic       round_rst_s;
    logic       sync_meta_r;
    logic       key_sync_r;
    key_state_e key_state_r;
    logic       human_hit_s;
    logic       press_next_s;

    // Either reset source restarts the key path and clears the output.
    assign round_rst_s = Reset | freset;

    // Two-flop synchronizer on the inverted key; resets to "held" so a key
    // already down across a reset is not mistaken for a fresh press.
    always_ff @(posedge Clock) begin
        if (round_rst_s) begin
            sync_meta_r <= 1'b1;
            key_sync_r  <= 1'b1;
        end else begin
            sync_meta_r <= ~key_n;
            key_sync_r  <= sync_meta_r;
        end
    end

    // Press-edge FSM: a press is only accepted after a release has been seen.
    // No debounce: one released sample is enough to re-arm.
    always_ff @(posedge Clock) begin
        if (round_rst_s) begin
            key_state_r <= ST_HELD;
        end else begin
            case (key_state_r)
                ST_RELEASED: begin
                    if (key_sync_r) begin
                        key_state_r <= ST_HELD;
                    end else begin
                        key_state_r <= ST_RELEASED;
                    end
                end
                ST_HELD: begin
                    if (!key_sync_r) begin
                        key_state_r <= ST_RELEASED;
                    end else begin
                        key_state_r <= ST_HELD;
                    end
                end
                default: begin
                    key_state_r <= ST_HELD;
                end
            endcase
        end
    end

    // Human press event: the RELEASED -> HELD transition.
    always_comb begin
        human_hit_s = 1'b0;
        if ((key_state_r == ST_RELEASED) && key_sync_r) begin
            human_hit_s = 1'b1;
        end else begin
            human_hit_s = 1'b0;
        end
    end

`ifdef CPU_PLAYER_EN

    localparam int               DIV_W    = $clog2(TICK_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

    logic [9:0]       lfsr_r;
    logic [DIV_W-1:0] div_r;
    logic             tick_s;
    logic             cpu_hit_s;

    // Fibonacci LFSR x^10 + x^7 + 1 with XNOR feedback (all-ones is the
    // lock-up state, so an all-zero seed is legal).
    function automatic logic [9:0] lfsr_next(input logic [9:0] cur);
        lfsr_next = {cur[8:0], ~(cur[9] ^ cur[6])};
    endfunction

    // LFSR free-runs every cycle; only the full Reset reseeds it so each
    // round after freset sees a different sequence.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    // Decision-interval divider, 0 .. TICK_CYCLES-1, restarted each round.
    always_ff @(posedge Clock) begin
        if (round_rst_s) begin
            div_r <= DIV_ZERO;
        end else if (div_r == DIV_LAST) begin
            div_r <= DIV_ZERO;
        end else begin
            div_r <= div_r + DIV_ONE;
        end
    end

    // CPU decision at each tick and selection of the press source. The
    // unsigned compare against {0,speed} makes speed=0 never fire and
    // speed=511 fire on roughly half of the ticks.
    always_comb begin
        tick_s       = 1'b0;
        cpu_hit_s    = 1'b0;
        press_next_s = 1'b0;
        tick_s = (div_r == DIV_LAST);
        if (tick_s && (lfsr_r < {1'b0, speed})) begin
            cpu_hit_s = 1'b1;
        end else begin
            cpu_hit_s = 1'b0;
        end
        if (cpu_mode) begin
            press_next_s = cpu_hit_s;
        end else begin
            press_next_s = human_hit_s;
        end
    end

`else

    // CPU-only inputs and parameters have no function in this build.
    logic unused_s;
    assign unused_s = ^{cpu_mode, speed, LFSR_SEED, 1'(TICK_CYCLES)};

    // Human key is the only press source.
    always_comb begin
        press_next_s = 1'b0;
        press_next_s = human_hit_s;
    end

`endif

    // Registered press pulse, forced low in any reset cycle.
    always_ff @(posedge Clock) begin
        if (round_rst_s) begin
            press <= 1'b0;
        end else begin
            press <= press_next_s;
        end
    end

endmodule
